coverfloat_vector_sequencer: RTL
================================

// Module: coverfloat_vector_sequencer
// PURPOSE
//  Schedules covervector streams from N_SRC sources (one per test file) onto the single coverage-sample port.
//  - Round-robin arbitration with per-file lock: a granted source streams until its last beat.
//  - Unpacks each vector into coverfloat fields and presents one registered sample per handshake.
//  - Counts sampled vectors; flags completion when every source has delivered its last beat.
// PARAMETERS
//  N_SRC   4    number of covervector sources (>=1)
//  CNT_W   32   width of vector/drop counters
// PORTS
//  clk            in   1              clock
//  reset          in   1              asynchronous, active-high reset
//  src_valid      in   N_SRC          source i has a vector
//  src_ready      out  N_SRC          source i vector accepted this cycle
//  src_last       in   N_SRC          vector is final beat of source i's file
//  src_vector     in   N_SRC x CV_W   packed covervectors (CV_W = COVER_VECTOR_WIDTH = 804)
//  smp_valid      out  1              sample fields valid
//  smp_ready      in   1              coverage side consumes sample
//  smp_op/rm/a/b/c/operandFmt/result/resultFmt/exceptionBits/intermS/intermX/intermM  out  field widths below
//  smp_src        out  $clog2(N_SRC)  source index of current sample (min width 1)
//  fmt_mask       in   16             operandFmt filter mask (see CONFIGURATION)
//  vector_count   out  CNT_W          samples handed off
//  drop_count     out  CNT_W          vectors filtered out
//  all_done       out  1              every source finished
// BEHAVIOUR
//  Field layout (MSB first): op[803:772] rm[771:764] a[763:636] b[635:508] c[507:380]
//   operandFmt[379:372] result[371:244] resultFmt[243:236] exceptionBits[235:228]
//   discard[227:225] intermS[224] intermX[223:192] intermM[191:0]. discard is not output.
//  Reset: all outputs 0; FSM IDLE; src_done mask 0; last_grant = N_SRC-1.
//  FSM:
//   IDLE   grant first i with src_valid[i] & ~src_done[i], searching from last_grant+1 with wrap; -> STREAM.
//          If all done -> DONE. No acceptance in IDLE: 1 idle cycle between files.
//   STREAM src_ready[g] = src_valid[g] & (~smp_valid | smp_ready); all other src_ready = 0.
//          Accepted beat with src_last[g]: set src_done[g], last_grant = g;
//          -> DONE if mask becomes all-ones, else -> IDLE.
//   DONE   all_done = 1 (sticky until reset). No further acceptance; a pending sample still drains.
//  Output stage: one register, latency 1 from acceptance to smp_valid. Fields/smp_src held stable while smp_valid & ~smp_ready.
//  Accept and handoff in the same cycle give back-to-back throughput.
//  vector_count increments on smp_valid & smp_ready; saturates at all-ones.
//  src_last on an empty source is not special: the last beat is a real vector.
//  Asynchronous reset mid-stream: everything cleared at once; a partially streamed file is restarted by the source, not the block.
// CONFIGURATION
//  COVERFLOAT_FMT_FILTER_EN defined:
//   - An accepted vector with fmt_mask[operandFmt[3:0]] == 0 is consumed (src_ready high, last honoured).
//   - It produces no sample; drop_count increments (saturating).
//  Undefined: fmt_mask ignored, drop_count tied to 0, every accepted vector sampled.
// STRUCTURE
//  coverfloat_pkg: CV_W, per-field width/offset localparams, seq_state_t enum {IDLE, STREAM, DONE},
//   cv_fields_t packed struct with unpack function.
//  One sub-module: coverfloat_rr_arbiter (request vector + last_grant -> one-hot grant + index).
// TESTING
//  1. N_SRC=2, src0 3 beats, src1 2 beats, smp_ready=1 -> samples src0 x3, then src1 x2; vector_count=5; all_done after 5th accept.
//  2. Both valid at reset release -> src0 granted first; src1 valid during src0 file -> not interleaved.
//  3. smp_ready low 4 cycles mid-file -> smp fields stable, src_ready=0, no loss or duplicate; count unchanged until release.
//  4. Vector with op=32'h1, a=128'h3FFF8000_0, intermS=1 -> smp_op=1, smp_a matches, smp_intermS=1; discard bits set to 3'b111 ignored.
//  5. Assert reset during 2nd beat of a file -> smp_valid=0 and counts=0 within the same cycle; arbitration restarts at src0.
//  6. FILTER_EN, fmt_mask=16'h0002, vectors operandFmt 1,0,1 -> 2 samples, drop_count=1; with last on the dropped beat, the file still completes.

Source files
------------

// File: rtl/coverfloat_pkg.sv
// Shared covervector layout: total width, per-field widths/offsets, sequencer states and unpacking.
// Latency: none (types, constants and a pure combinational helper only).
// Backpressure: not applicable.
package coverfloat_pkg;

    localparam int CV_W   = 804;

    localparam int OP_W   = 32;
    localparam int RM_W   = 8;
    localparam int VAL_W  = 128;
    localparam int FMT_W  = 8;
    localparam int EXC_W  = 8;
    localparam int DISC_W = 3;
    localparam int IX_W   = 32;
    localparam int IM_W   = 192;

    localparam int OP_LSB   = 772;
    localparam int RM_LSB   = 764;
    localparam int A_LSB    = 636;
    localparam int B_LSB    = 508;
    localparam int C_LSB    = 380;
    localparam int OFMT_LSB = 372;
    localparam int RES_LSB  = 244;
    localparam int RFMT_LSB = 236;
    localparam int EXC_LSB  = 228;
    localparam int DISC_LSB = 225;
    localparam int IS_LSB   = 224;
    localparam int IX_LSB   = 192;
    localparam int IM_LSB   = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [RM_W-1:0]   rm;
        logic [VAL_W-1:0]  a;
        logic [VAL_W-1:0]  b;
        logic [VAL_W-1:0]  c;
        logic [FMT_W-1:0]  operandFmt;
        logic [VAL_W-1:0]  result;
        logic [FMT_W-1:0]  resultFmt;
        logic [EXC_W-1:0]  exceptionBits;
        logic [DISC_W-1:0] discard;
        logic              intermS;
        logic [IX_W-1:0]   intermX;
        logic [IM_W-1:0]   intermM;
    } cv_fields_t;

    function automatic cv_fields_t unpack_cv(input logic [CV_W-1:0] v);
        cv_fields_t f;
        f.op            = v[OP_LSB   +: OP_W];
        f.rm            = v[RM_LSB   +: RM_W];
        f.a             = v[A_LSB    +: VAL_W];
        f.b             = v[B_LSB    +: VAL_W];
        f.c             = v[C_LSB    +: VAL_W];
        f.operandFmt    = v[OFMT_LSB +: FMT_W];
        f.result        = v[RES_LSB  +: VAL_W];
        f.resultFmt     = v[RFMT_LSB +: FMT_W];
        f.exceptionBits = v[EXC_LSB  +: EXC_W];
        f.discard       = v[DISC_LSB +: DISC_W];
        f.intermS       = v[IS_LSB];
        f.intermX       = v[IX_LSB   +: IX_W];
        f.intermM       = v[IM_LSB   +: IM_W];
        return f;
    endfunction

endpackage

// File: rtl/coverfloat_rr_arbiter.sv
// Round-robin pick: first requester after last_grant (with wrap) -> one-hot grant, index, valid.
// Latency: combinational.
// Backpressure: none; the caller decides when to register the pick.
// Ports: req (request per source), last_grant (index of previous winner),
//        gnt (one-hot), gnt_idx (binary index), gnt_vld (some request present).
module coverfloat_rr_arbiter #(
    parameter int N_SRC = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_SRC-1:0] req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N_SRC-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld
);

    always_comb begin : search
        int               idx;
        logic [N_SRC-1:0] rot;
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = 0;
        rot     = '0;
        // Candidate order starts just after the previous winner, so the
        // previous winner is considered last.
        for (int k = 1; k <= N_SRC; k++) begin
            idx = (int'(last_grant) + k) % N_SRC;
            rot = req >> idx;
            if (!gnt_vld && rot[0]) begin
                gnt_vld = 1'b1;
                gnt     = N_SRC'(1) << idx;
                gnt_idx = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/coverfloat_vector_sequencer.sv
// Schedules per-file covervector streams round-robin (file-locked) onto one registered coverage-sample port.
// Latency: 1 cycle from source acceptance to smp_valid; one idle cycle between files.
// Backpressure: src_ready only while the output register is empty or being consumed; held sample is stable.
// Ports: clk/reset (async, active-high); src_valid/src_ready/src_last/src_vector per source;
//        smp_valid/smp_ready plus unpacked smp_* fields and smp_src; fmt_mask filter input;
//        vector_count (handoffs), drop_count (filtered), all_done (sticky completion).
// Optional build macro COVERFLOAT_FMT_FILTER_EN: vectors whose fmt_mask[operandFmt[3:0]] is 0
// are consumed without producing a sample and counted in drop_count.
module coverfloat_vector_sequencer
    import coverfloat_pkg::*;
#(
    parameter  int N_SRC = 4,
    parameter  int CNT_W = 32,
    localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_SRC-1:0]           src_valid,
    output logic [N_SRC-1:0]           src_ready,
    input  logic [N_SRC-1:0]           src_last,
    input  logic [N_SRC-1:0][CV_W-1:0] src_vector,
    output logic                       smp_valid,
    input  logic                       smp_ready,
    output logic [OP_W-1:0]            smp_op,
    output logic [RM_W-1:0]            smp_rm,
    output logic [VAL_W-1:0]           smp_a,
    output logic [VAL_W-1:0]           smp_b,
    output logic [VAL_W-1:0]           smp_c,
    output logic [FMT_W-1:0]           smp_operandFmt,
    output logic [VAL_W-1:0]           smp_result,
    output logic [FMT_W-1:0]           smp_resultFmt,
    output logic [EXC_W-1:0]           smp_exceptionBits,
    output logic                       smp_intermS,
    output logic [IX_W-1:0]            smp_intermX,
    output logic [IM_W-1:0]            smp_intermM,
    output logic [SRC_W-1:0]           smp_src,
    input  logic [15:0]                fmt_mask,
    output logic [CNT_W-1:0]           vector_count,
    output logic [CNT_W-1:0]           drop_count,
    output logic                       all_done
);

    seq_state_t       state;
    logic [N_SRC-1:0] src_done;
    logic [SRC_W-1:0] last_grant;
    logic [SRC_W-1:0] grant;
    logic [N_SRC-1:0] grant_oh;

    logic [N_SRC-1:0] arb_gnt;
    logic [SRC_W-1:0] arb_idx;
    logic             arb_vld;

    logic             take_ok;
    logic             acc;
    logic             cur_last;
    cv_fields_t       cv;
    logic             keep;
    logic [2:0]       unused_discard;

    coverfloat_rr_arbiter #(
        .N_SRC (N_SRC),
        .IDX_W (SRC_W)
    ) u_arb (
        .req        (src_valid & ~src_done),
        .last_grant (last_grant),
        .gnt        (arb_gnt),
        .gnt_idx    (arb_idx),
        .gnt_vld    (arb_vld)
    );

    // Accept only from the locked source, and only if the output register
    // is free now or is being emptied this same cycle.
    assign take_ok   = (state == STREAM) && (!smp_valid || smp_ready);
    assign src_ready = grant_oh & src_valid & {N_SRC{take_ok}};
    assign acc       = |src_ready;
    assign cur_last  = src_last[grant];
    assign cv        = unpack_cv(src_vector[grant]);
    assign unused_discard = cv.discard;

`ifdef COVERFLOAT_FMT_FILTER_EN
    assign keep = fmt_mask[cv.operandFmt[3:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_count <= '0;
        end else if (acc && !keep && drop_count != {CNT_W{1'b1}}) begin
            drop_count <= drop_count + 1'b1;
        end
    end
`else
    logic unused_fmt_mask;
    assign unused_fmt_mask = ^fmt_mask;
    assign keep            = 1'b1;
    assign drop_count      = '0;
`endif

    // Sequencer: pick a file in IDLE, stream it to its last beat, record completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            src_done   <= '0;
            last_grant <= SRC_W'(N_SRC - 1);
            grant      <= '0;
            grant_oh   <= '0;
            all_done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (&src_done) begin
                        state    <= DONE;
                        all_done <= 1'b1;
                    end else if (arb_vld) begin
                        grant    <= arb_idx;
                        grant_oh <= arb_gnt;
                        state    <= STREAM;
                    end
                end
                STREAM: begin
                    if (acc && cur_last) begin
                        src_done   <= src_done | grant_oh;
                        last_grant <= grant;
                        if (&(src_done | grant_oh)) begin
                            state    <= DONE;
                            all_done <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DONE: begin
                    all_done <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Single output register; a filtered beat leaves it untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            smp_valid         <= 1'b0;
            smp_op            <= '0;
            smp_rm            <= '0;
            smp_a             <= '0;
            smp_b             <= '0;
            smp_c             <= '0;
            smp_operandFmt    <= '0;
            smp_result        <= '0;
            smp_resultFmt     <= '0;
            smp_exceptionBits <= '0;
            smp_intermS       <= 1'b0;
            smp_intermX       <= '0;
            smp_intermM       <= '0;
            smp_src           <= '0;
            vector_count      <= '0;
        end else begin
            if (acc && keep) begin
                smp_valid         <= 1'b1;
                smp_op            <= cv.op;
                smp_rm            <= cv.rm;
                smp_a             <= cv.a;
                smp_b             <= cv.b;
                smp_c             <= cv.c;
                smp_operandFmt    <= cv.operandFmt;
                smp_result        <= cv.result;
                smp_resultFmt     <= cv.resultFmt;
                smp_exceptionBits <= cv.exceptionBits;
                smp_intermS       <= cv.intermS;
                smp_intermX       <= cv.intermX;
                smp_intermM       <= cv.intermM;
                smp_src           <= grant;
            end else if (smp_ready) begin
                smp_valid <= 1'b0;
            end
            if (smp_valid && smp_ready && vector_count != {CNT_W{1'b1}}) begin
                vector_count <= vector_count + 1'b1;
            end
        end
    end

endmodule
